// File: rtl/imem_loader.sv
// imem_loader: UART boot loader filling instruction memory with framed LE 32-bit words (optional checksum: LOADER_CHECKSUM_EN).
// Latency: byte_valid at stop-bit centre (~9.5 bits after start edge); write one cycle after a word's 4th byte.
// Backpressure: none; the host paces the byte stream and every write strobe is a single cycle.
module imem_loader #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        write,
    output logic [31:0] addr_in,
    output logic [31:0] data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int          CPB     = CLK_HZ / BAUD;
    localparam logic [15:0] BIT_M1  = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {F_SYNC, F_LEN0, F_LEN1, F_DATA, F_WRITE, F_CHK, F_DONE} f_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam f_state_t F_TAIL = F_CHK;
`else
    localparam f_state_t F_TAIL = F_DONE;
`endif

    rx_state_t   r_rx_state, w_rx_next;
    logic [1:0]  r_sync;
    logic        r_rx_prev;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_byte_vld;
    logic [7:0]  r_byte_dat;
    logic        r_ferr;

    f_state_t    r_f_state, w_f_next;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [1:0]  r_k;
    logic [23:0] r_word;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_error;

    logic        w_rx;
    logic        w_tick_bit;
    logic        w_tick_half;
    logic [15:0] w_n;
    logic        w_len_bad;
    logic        w_last;

    assign w_rx        = r_sync[1];
    assign w_tick_bit  = (r_cnt == BIT_M1);
    assign w_tick_half = (r_cnt == HALF_M1);
    assign w_n         = {r_byte_dat, r_len_lo};
    assign w_len_bad   = ({16'd0, w_n} > DEPTH_U);
    assign w_last      = ((r_idx + 16'd1) == r_len);

    // Two-flop synchronizer plus a delayed copy for start-edge detection; idle is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    // RX next state: start edge, half-bit glitch check, 8 data bits, stop bit.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !w_rx) w_rx_next = RX_START;
            RX_START: if (w_tick_half) w_rx_next = w_rx ? RX_IDLE : RX_BITS;
            RX_BITS:  if (w_tick_bit && (r_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_tick_bit) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: bit timer re-zeroed at the start centre so later samples land mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
            r_byte_dat <= '0;
            r_ferr     <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_ferr     <= 1'b0;
            if ((r_rx_state == RX_IDLE) || w_tick_bit || ((r_rx_state == RX_START) && w_tick_half))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;
            if ((r_rx_state == RX_BITS) && w_tick_bit) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if ((r_rx_state == RX_STOP) && w_tick_bit) begin
                if (w_rx) begin
                    r_byte_vld <= 1'b1;
                    r_byte_dat <= r_shift;
                end else begin
                    r_ferr <= 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR of length and payload bytes, restarted at each sync byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_csum <= '0;
        else if ((r_f_state == F_SYNC) && r_byte_vld && (r_byte_dat == 8'hA5))
            r_csum <= '0;
        else if (r_byte_vld && ((r_f_state == F_LEN0) || (r_f_state == F_LEN1) || (r_f_state == F_DATA)))
            r_csum <= r_csum ^ r_byte_dat;
    end
`endif

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_f_state <= F_SYNC;
        else        r_f_state <= w_f_next;
    end

    // Frame next state; a framing error anywhere before DONE drops back to hunting for 0xA5.
    always_comb begin
        w_f_next = r_f_state;
        case (r_f_state)
            F_SYNC:  if (r_byte_vld && (r_byte_dat == 8'hA5)) w_f_next = F_LEN0;
            F_LEN0:  if (r_byte_vld) w_f_next = F_LEN1;
            F_LEN1:  if (r_byte_vld) w_f_next = w_len_bad ? F_SYNC : ((w_n == 16'd0) ? F_TAIL : F_DATA);
            F_DATA:  if (r_byte_vld && (r_k == 2'd3)) w_f_next = F_WRITE;
            F_WRITE: w_f_next = w_last ? F_TAIL : F_DATA;
`ifdef LOADER_CHECKSUM_EN
            F_CHK:   if (r_byte_vld) w_f_next = (r_byte_dat == r_csum) ? F_DONE : F_SYNC;
`endif
            F_DONE:  w_f_next = F_DONE;
            default: w_f_next = F_SYNC;
        endcase
        if (r_ferr && (r_f_state != F_DONE)) w_f_next = F_SYNC;
    end

    // Frame datapath: length latch, word assembly, write address/data and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_lo <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_k      <= '0;
            r_word   <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_f_state)
                F_SYNC: if (r_byte_vld && (r_byte_dat == 8'hA5)) r_error <= 1'b0;
                F_LEN0: if (r_byte_vld) r_len_lo <= r_byte_dat;
                F_LEN1: if (r_byte_vld) begin
                    r_len <= w_n;
                    r_idx <= '0;
                    r_k   <= '0;
                    if (w_len_bad) r_error <= 1'b1;
                end
                F_DATA: if (r_byte_vld) begin
                    r_k <= r_k + 2'd1;
                    case (r_k)
                        2'd0: r_word[7:0]   <= r_byte_dat;
                        2'd1: r_word[15:8]  <= r_byte_dat;
                        2'd2: r_word[23:16] <= r_byte_dat;
                        default: begin
                            r_data <= {r_byte_dat, r_word};
                            r_addr <= {14'd0, r_idx, 2'b00};
                        end
                    endcase
                end
                F_WRITE: r_idx <= r_idx + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                F_CHK: if (r_byte_vld && (r_byte_dat != r_csum)) r_error <= 1'b1;
`endif
                default: ;
            endcase
            if (r_ferr && (r_f_state != F_DONE)) r_error <= 1'b1;
        end
    end

    // Outputs decoded from frame state; address/data hold between strobes.
    always_comb begin
        write    = (r_f_state == F_WRITE);
        done     = (r_f_state == F_DONE);
        cpu_hold = (r_f_state != F_DONE);
        error    = r_error;
        addr_in  = r_addr;
        data     = r_data;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames at 8 clocks/bit with write capture and sticky-flag checks.
// Latency: each UART byte takes 10 bit periods plus a 2-bit idle gap.
// Backpressure: not applicable; the bench drives rx open-loop.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        write;
    logic [31:0] addr_in;
    logic [31:0] data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_err = 0;
    int n_chk = 0;
    int wr_cnt = 0;
    int b2b = 0;
    int base = 0;
    logic prev_wr = 1'b0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [7:0] frame1 [11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h01, 8'hFE, 8'h23, 8'h2E, 8'h11, 8'h00};

    always #5 clk = ~clk;

    imem_loader #(.CLK_HZ(921600), .BAUD(115200), .DEPTH_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .write(write), .addr_in(addr_in),
        .data(data), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture every write strobe and count back-to-back strobes.
    always @(negedge clk) begin
        if (write) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = addr_in;
                wr_data[wr_cnt] = data;
            end
            wr_cnt++;
            if (prev_wr) b2b++;
        end
        prev_wr = write;
    end

    // Watchdog: the whole sequence must finish well within this bound.
    initial begin
        #2_000_000;
        n_err++;
        $error("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(8);
        end
        rx = stop_bit;
        tick(8);
        rx = 1'b1;
        tick(16);
    endtask

    task automatic send_frame1();
        for (int i = 0; i < 11; i++) send_byte(frame1[i], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin
        tick(3);
        chk("rst_write", write, 1'b0);
        chk("rst_addr", addr_in, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        rst_n = 1'b1;
        tick(3);

        // Reset pulse in the middle of a byte after a sync byte.
        send_byte(8'hA5, 1'b1);
        rx = 1'b0;
        tick(20);
        rst_n = 1'b0;
        tick(2);
        chk("mid_write", write, 1'b0);
        chk("mid_addr", addr_in, 32'h0);
        chk("mid_data", data, 32'h0);
        chk("mid_hold", cpu_hold, 1'b1);
        chk("mid_done", done, 1'b0);
        chk("mid_error", error, 1'b0);
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);

`ifndef LOADER_CHECKSUM_EN
        // Two-word frame.
        base = wr_cnt;
        send_frame1();
        tick(10);
        chk("f1_wrcnt", wr_cnt - base, 2);
        chk("f1_addr0", wr_addr[base], 32'h0);
        chk("f1_data0", wr_data[base], 32'hFE010113);
        chk("f1_addr1", wr_addr[base+1], 32'h4);
        chk("f1_data1", wr_data[base+1], 32'h00112E23);
        chk("f1_done", done, 1'b1);
        chk("f1_hold", cpu_hold, 1'b0);
        chk("f1_error", error, 1'b0);
        chk("f1_b2b", b2b, 0);

        // Leading junk before the frame is ignored.
        do_reset();
        chk("lead_rst_done", done, 1'b0);
        base = wr_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_frame1();
        tick(10);
        chk("lead_wrcnt", wr_cnt - base, 2);
        chk("lead_data0", wr_data[base], 32'hFE010113);
        chk("lead_addr1", wr_addr[base+1], 32'h4);
        chk("lead_data1", wr_data[base+1], 32'h00112E23);
        chk("lead_done", done, 1'b1);

        // Oversized length N=257 then a good frame.
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        tick(4);
        chk("len_error", error, 1'b1);
        chk("len_wrcnt", wr_cnt - base, 0);
        chk("len_hold", cpu_hold, 1'b1);
        base = wr_cnt;
        send_frame1();
        tick(10);
        chk("len_rec_error", error, 1'b0);
        chk("len_rec_done", done, 1'b1);
        chk("len_rec_wrcnt", wr_cnt - base, 2);

        // Framing error on the second data byte; the rest of the frame is then ignored.
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h01, 1'b0);
        tick(2);
        chk("fe_error", error, 1'b1);
        chk("fe_hold", cpu_hold, 1'b1);
        for (int i = 5; i < 11; i++) send_byte(frame1[i], 1'b1);
        tick(10);
        chk("fe_wrcnt", wr_cnt - base, 0);
        chk("fe_done", done, 1'b0);
        chk("fe_error_hold", error, 1'b1);
`else
        // Checksum match: one word then done.
        base = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(4);
        chk("ck_wrcnt", wr_cnt - base, 1);
        chk("ck_addr0", wr_addr[base], 32'h0);
        chk("ck_data0", wr_data[base], 32'h00000013);
        chk("ck_predone", done, 1'b0);
        send_byte(8'h12, 1'b1);
        tick(4);
        chk("ck_done", done, 1'b1);
        chk("ck_hold", cpu_hold, 1'b0);
        chk("ck_error", error, 1'b0);

        // Checksum mismatch.
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        tick(4);
        chk("ckbad_error", error, 1'b1);
        chk("ckbad_done", done, 1'b0);
        chk("ckbad_hold", cpu_hold, 1'b1);
        chk("ckbad_wrcnt", wr_cnt - base, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
